// File: rtl/frame_decimator_pkg.sv
// Shared constants, state encoding and helpers for the frame decimator write stage.
package frame_decimator_pkg;

  // Default geometry: 640x480 camera frame stored at 1/4 in each direction (160x120).
  localparam int unsigned SrcWDefault    = 640;
  localparam int unsigned SrcHDefault    = 480;
  localparam int unsigned DecimLgDefault = 2;
  localparam int unsigned AddrWDefault   = 15;
  localparam int unsigned PixWDefault    = 16;

  // Capture FSM states; encodings are fixed so they line up with the read-side debug views.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWaitSof = 3'd1,
    StCapture = 3'd2,
    StLocked  = 3'd3,
    StRelease = 3'd4
  } state_e;

  // Number of pixels stored per decimated frame.
  function automatic int unsigned calc_npix(input int unsigned src_w, input int unsigned src_h,
                                            input int unsigned decim_lg);
    return (src_w >> decim_lg) * (src_h >> decim_lg);
  endfunction

  localparam int unsigned NpixDefault = calc_npix(SrcWDefault, SrcHDefault, DecimLgDefault);

endpackage

// File: rtl/frame_decimator_sync_edge_detect.sv
// Registered copy of a 1-bit level with single-cycle rise and fall pulses.
module frame_decimator_sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic din_q;

  // Previous-cycle copy of the input; cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din;
    end
  end

  assign rise = din & ~din_q;
  assign fall = ~din & din_q;

endmodule

// File: rtl/frame_decimator.sv
// Capture-side write stage: decimates the camera pixel stream, produces Bram writes and
// holds the stored frame until the VGA read side acknowledges it.
module frame_decimator
  import frame_decimator_pkg::*;
#(
  parameter int unsigned SRC_W    = SrcWDefault,
  parameter int unsigned SRC_H    = SrcHDefault,
  parameter int unsigned DECIM_LG = DecimLgDefault,
  parameter int unsigned ADDR_W   = AddrWDefault,
  parameter int unsigned PIX_W    = PixWDefault
) (
  input  logic              Clk_i,
  input  logic              Reset_i,
  input  logic              Enable_i,
  input  logic              Vsync_i,
  input  logic              Href_i,
  input  logic [PIX_W-1:0]  Pixel_i,
  input  logic              Pixel_Valid_i,
  input  logic              Frame_Ack_i,
  output logic              Wr_En_o,
  output logic [ADDR_W-1:0] Wr_Addr_o,
  output logic [PIX_W-1:0]  Wr_Data_o,
  output logic              Frame_Available_o,
  output logic              Buff_Locked_o,
  output logic              Frame_Error_o
);

  localparam int unsigned ColW      = $clog2(SRC_W + 1);
  localparam int unsigned RowW      = $clog2(SRC_H + 1);
  // One extra bit so the counter can hold NPIX itself (the "frame complete" value).
  localparam int unsigned AddrCntW  = ADDR_W + 1;
  localparam int unsigned Npix      = calc_npix(SRC_W, SRC_H, DECIM_LG);
  localparam int unsigned DecimMask = (1 << DECIM_LG) - 1;

  state_e state_q, state_d;

  logic [ColW-1:0]     col;
  logic [RowW-1:0]     row;
  logic [AddrCntW-1:0] addr;

  logic vs_rise, vs_fall, hr_rise, hr_fall;
  logic in_window, frame_full, pix_wr, frame_err;

  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [PIX_W-1:0]  wr_data_q;
  logic              err_q;

  // Line-start edge is not needed; sink it so it is visibly intentional.
  logic unused_hr_rise;
  assign unused_hr_rise = hr_rise;

  frame_decimator_sync_edge_detect u_vsync_edge (
    .clk   (Clk_i),
    .rst_n (Reset_i),
    .din   (Vsync_i),
    .rise  (vs_rise),
    .fall  (vs_fall)
  );

  frame_decimator_sync_edge_detect u_href_edge (
    .clk   (Clk_i),
    .rst_n (Reset_i),
    .din   (Href_i),
    .rise  (hr_rise),
    .fall  (hr_fall)
  );

  // Pixel sits on the decimation grid and inside the nominal source frame.
  assign in_window = (col < ColW'(SRC_W)) && (row < RowW'(SRC_H)) &&
                     ((col & ColW'(DecimMask)) == '0) && ((row & RowW'(DecimMask)) == '0);
  assign frame_full = (addr == AddrCntW'(Npix));

  // State register.
  always_ff @(posedge Clk_i) begin
    if (!Reset_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping Enable_i abandons whatever is in progress.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (Enable_i) state_d = StWaitSof;
      end
      StWaitSof: begin
        if (vs_fall) state_d = StCapture;
      end
      StCapture: begin
        if (vs_rise) state_d = frame_full ? StLocked : StWaitSof;
      end
      StLocked: begin
        if (Frame_Ack_i) state_d = StRelease;
      end
      StRelease: begin
        if (!Frame_Ack_i) state_d = StWaitSof;
      end
      default: state_d = StIdle;
    endcase
    if (!Enable_i) state_d = StIdle;
  end

  // Outputs decoded from state plus the write/error strobes feeding the register stage.
  always_comb begin
    Frame_Available_o = (state_q == StLocked);
    Buff_Locked_o     = (state_q == StLocked) || (state_q == StRelease);
    pix_wr            = (state_q == StCapture) && Enable_i && Pixel_Valid_i && in_window &&
                        !frame_full;
    frame_err         = (state_q == StCapture) && Enable_i && vs_rise && !frame_full;
  end

  // Column/row position within the source frame and the linear write address.
  always_ff @(posedge Clk_i) begin
    if (!Reset_i) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if ((state_q == StWaitSof) && vs_fall) begin
      col  <= '0;
      row  <= '0;
      addr <= '0;
    end else if ((state_q == StCapture) && Enable_i) begin
      // A pixel arriving with the line end was already judged on the old position above.
      if (hr_fall) begin
        col <= '0;
        if (row != RowW'(SRC_H)) row <= row + 1'b1;
      end else if (Pixel_Valid_i && (col != ColW'(SRC_W))) begin
        col <= col + 1'b1;
      end
      if (pix_wr) addr <= addr + 1'b1;
    end
  end

  // Registered Bram write port and error pulse; everything clears while disabled.
  always_ff @(posedge Clk_i) begin
    if (!Reset_i || !Enable_i) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q <= pix_wr;
      err_q   <= frame_err;
      if (pix_wr) begin
        wr_addr_q <= addr[ADDR_W-1:0];
        wr_data_q <= Pixel_i;
      end
    end
  end

  assign Wr_En_o       = wr_en_q;
  assign Wr_Addr_o     = wr_addr_q;
  assign Wr_Data_o     = wr_data_q;
  assign Frame_Error_o = err_q;

endmodule

// File: tb/tb_frame_decimator.sv
// Randomised bench for frame_decimator using a reduced 32x24 source frame.
module tb_frame_decimator;

  localparam int unsigned W    = 32;
  localparam int unsigned H    = 24;
  localparam int unsigned DL   = 2;
  localparam int unsigned AW   = 6;
  localparam int unsigned PW   = 16;
  localparam int unsigned D    = 1 << DL;
  localparam int unsigned NPIX = (W / D) * (H / D);

  logic          clk = 1'b0;
  logic          rst_n, enable, vsync, href, pix_valid, ack;
  logic [PW-1:0] pixel;
  logic          wr_en, fa, bl, fe;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_data;

  always #5 clk = ~clk;

  frame_decimator #(
    .SRC_W    (W),
    .SRC_H    (H),
    .DECIM_LG (DL),
    .ADDR_W   (AW),
    .PIX_W    (PW)
  ) dut (
    .Clk_i             (clk),
    .Reset_i           (rst_n),
    .Enable_i          (enable),
    .Vsync_i           (vsync),
    .Href_i            (href),
    .Pixel_i           (pixel),
    .Pixel_Valid_i     (pix_valid),
    .Frame_Ack_i       (ack),
    .Wr_En_o           (wr_en),
    .Wr_Addr_o         (wr_addr),
    .Wr_Data_o         (wr_data),
    .Frame_Available_o (fa),
    .Buff_Locked_o     (bl),
    .Frame_Error_o     (fe)
  );

  typedef struct {
    int          addr;
    logic [15:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  bit          started = 0;
  bit          capturing = 0;
  bit          last_locked = 0;
  int          wcount = 0;
  int          wr_total = 0;
  int          max_addr = -1;
  logic [15:0] cap_mem [0:63];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, {31'b0, wr_en}, 0);
    check({tag, "_wr_addr"}, {26'b0, wr_addr}, 0);
    check({tag, "_wr_data"}, {16'b0, wr_data}, 0);
    check({tag, "_avail"}, {31'b0, fa}, 0);
    check({tag, "_locked"}, {31'b0, bl}, 0);
    check({tag, "_error"}, {31'b0, fe}, 0);
  endtask

  // Compare process: every write must match the next expected write from the model.
  always @(negedge clk) begin
    if (started) begin
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {31'b0, wr_en}, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", {26'b0, wr_addr}, e.addr);
          check("wr_data", {16'b0, wr_data}, {16'b0, e.data});
          cap_mem[wr_addr] = wr_data;
          wr_total++;
          if (int'(wr_addr) > max_addr) max_addr = int'(wr_addr);
        end
      end
      check("avail_without_lock", {31'b0, fa & ~bl}, 0);
      check("write_while_locked", {31'b0, wr_en & bl}, 0);
    end
  end

  // Model: a pixel is stored if it lies on the decimation grid inside WxH, in arrival order.
  task automatic put_pixel(input int r, input int c, input logic [15:0] px, input bit hfall);
    pixel     = px;
    pix_valid = 1'b1;
    href      = !hfall;
    if (capturing && r < H && c < W && (r % D) == 0 && (c % D) == 0 && wcount < NPIX) begin
      exp_q.push_back('{wcount, px});
      wcount++;
    end
    step();
    pix_valid = 1'b0;
  endtask

  // act: 0 none, 1 reset pulse mid-line, 2 enable drop mid-line then re-raise two lines later.
  task automatic frame(input int nl, input int np, input bit pat, input bit cap,
                       input int act, input int act_line, input bit exp_locked);
    logic [15:0] px;
    bit          last;
    int          r8, c8;
    capturing = cap;
    wcount    = 0;
    vsync     = 1'b0;
    repeat (3) step();
    for (int r = 0; r < nl; r++) begin
      href = 1'b1;
      step();
      for (int c = 0; c < np; c++) begin
        if (act == 1 && r == act_line && c == np / 2) begin
          rst_n     = 1'b0;
          capturing = 0;
          step();
          rst_n = 1'b1;
          @(negedge clk);
          check_all_zero("reset");
          step();
        end
        if (act == 2 && r == act_line && c == np / 2) begin
          enable    = 1'b0;
          capturing = 0;
          step();
          @(negedge clk);
          check_all_zero("disable");
          step();
        end
        if (act == 2 && r == act_line + 2 && c == 0) enable = 1'b1;
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) step();
        r8   = r;
        c8   = c;
        px   = pat ? {r8[7:0], c8[7:0]} : 16'($urandom);
        last = (c == np - 1) && ($urandom_range(0, 1) == 1);
        put_pixel(r, c, px, last);
      end
      href = 1'b0;
      repeat ($urandom_range(2, 4)) step();
    end
    vsync = 1'b1;
    @(negedge clk);
    check("avail_at_vs_rise", {31'b0, fa}, capturing ? 0 : {31'b0, exp_locked});
    check("error_at_vs_rise", {31'b0, fe}, 0);
    step();
    @(negedge clk);
    last_locked = capturing && (wcount == NPIX);
    if (capturing && wcount != NPIX) begin
      check("error_pulse", {31'b0, fe}, 1);
      check("avail_after_error", {31'b0, fa}, 0);
      step();
      @(negedge clk);
      check("error_one_cycle", {31'b0, fe}, 0);
    end else begin
      check("avail_after_frame", {31'b0, fa}, {31'b0, last_locked | (!capturing & exp_locked)});
      check("locked_after_frame", {31'b0, bl}, {31'b0, last_locked | (!capturing & exp_locked)});
      check("no_error_pulse", {31'b0, fe}, 0);
    end
    repeat (3) step();
  endtask

  task automatic do_ack();
    ack = 1'b1;
    step();
    @(negedge clk);
    check("release_avail", {31'b0, fa}, 0);
    check("release_locked", {31'b0, bl}, 1);
    ack = 1'b0;
    step();
    @(negedge clk);
    check("after_release_locked", {31'b0, bl}, 0);
    step();
  endtask

  initial begin
    int base;
    int sel;
    rst_n     = 1'b0;
    enable    = 1'b0;
    vsync     = 1'b1;
    href      = 1'b0;
    pix_valid = 1'b0;
    pixel     = '0;
    ack       = 1'b0;
    repeat (3) step();
    started = 1;
    @(negedge clk);
    check_all_zero("por");
    rst_n = 1'b1;
    step();
    enable = 1'b1;
    repeat (3) step();

    // Clean patterned frame; literal expectations pin the model's address order.
    base = wr_total;
    frame(H, W, 1, 1, 0, 0, 0);
    check("t1_write_count", wr_total - base, 48);
    check("t1_max_addr", max_addr, 47);
    check("t1_addr0", {16'b0, cap_mem[0]}, 32'h0000);
    check("t1_addr9", {16'b0, cap_mem[9]}, 32'h0404);
    check("t1_addr47", {16'b0, cap_mem[47]}, 32'h141C);

    // Locked: next frame must write nothing, then handshake and capture again.
    base = wr_total;
    frame(H, W, 0, 0, 0, 0, 1);
    check("t2_locked_writes", wr_total - base, 0);
    do_ack();
    frame(H, W, 0, 1, 0, 0, 0);
    do_ack();

    // Short frame, then a full one starting again from address 0.
    frame(12, W, 0, 1, 0, 0, 0);
    frame(H, W, 0, 1, 0, 0, 0);
    do_ack();

    // Overlong lines and frame.
    max_addr = -1;
    base     = wr_total;
    frame(H + 10, W + 10, 0, 1, 0, 0, 0);
    check("t4_write_count", wr_total - base, 48);
    check("t4_max_addr", max_addr, 47);
    do_ack();

    // Reset mid-line, then a normal frame.
    frame(H, W, 0, 1, 1, 5, 0);
    frame(H, W, 0, 1, 0, 0, 0);
    do_ack();

    // Enable dropped and re-raised mid-frame, then a normal frame.
    frame(H, W, 0, 1, 2, 9, 0);
    frame(H, W, 0, 1, 0, 0, 0);
    do_ack();

    // Random mix of full, overlong and short frames.
    for (int i = 0; i < 8; i++) begin
      sel = $urandom_range(0, 2);
      case (sel)
        0:       frame(H, W, 0, 1, 0, 0, 0);
        1:       frame(H + $urandom_range(1, 8), W + $urandom_range(1, 8), 0, 1, 0, 0, 0);
        default: frame($urandom_range(1, H - D), W, 0, 1, 0, 0, 0);
      endcase
      if (last_locked) begin
        if ($urandom_range(0, 1) == 1) frame(H, W, 0, 0, 0, 0, 1);
        do_ack();
      end
    end

    repeat (5) step();
    check("pending_writes", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
